// File: rtl/wr3_addr_ctr_if.sv
// ----------------------------------------------------------------------------
// wr3_addr_ctr_if
//   Bundles the frame-sync, FIFO level, DDR write-request handshake and frame
//   status signals of the write-side address generator.
//
//   master : the address generator (drives request, address and frame status)
//   slave  : the DDR write port / ingress side (drives sync, level, ready, done)
//
//   wr_vs          frame sync, rising edge starts a frame
//   wr_fifo_cnt    words currently buffered in the ingress FIFO
//   wr_ddr_valid   burst write request valid
//   wr_ddr_ready   request accepted when valid & ready
//   wr_ddr_addr    burst start byte address
//   wr_burst_done  1-cycle pulse: accepted burst fully written
//   wr_image_cnt   index of the frame slot currently being written
//   wr_frame_done  1-cycle pulse on frame completion
//   wr_busy        high whenever the generator is not idle
// ----------------------------------------------------------------------------
interface wr3_addr_ctr_if #(
    parameter int ADDR_WIDTH     = 30,
    parameter int FIFO_CNT_WIDTH = 12
);
    logic                      wr_vs;
    logic [FIFO_CNT_WIDTH-1:0] wr_fifo_cnt;
    logic                      wr_ddr_valid;
    logic                      wr_ddr_ready;
    logic [ADDR_WIDTH-1:0]     wr_ddr_addr;
    logic                      wr_burst_done;
    logic [4:0]                wr_image_cnt;
    logic                      wr_frame_done;
    logic                      wr_busy;

    modport master (
        input  wr_vs, wr_fifo_cnt, wr_ddr_ready, wr_burst_done,
        output wr_ddr_valid, wr_ddr_addr, wr_image_cnt, wr_frame_done, wr_busy
    );

    modport slave (
        output wr_vs, wr_fifo_cnt, wr_ddr_ready, wr_burst_done,
        input  wr_ddr_valid, wr_ddr_addr, wr_image_cnt, wr_frame_done, wr_busy
    );
endinterface

// File: rtl/wr3_addr_ctr.sv
// ----------------------------------------------------------------------------
// wr3_addr_ctr
//   DDR write-side address generator for the video frame buffer ring. A rising
//   edge on wr_vs starts a frame; one burst request of WR_NUM words is issued
//   whenever the ingress FIFO holds a full burst, the frame slot is walked
//   linearly, and wr_image_cnt advances once per completed frame.
//
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   wr3_addr_ctr_if.master (sync, FIFO level, request handshake, status)
//
//   state | meaning
//   IDLE  | waiting for frame sync
//   WAIT  | frame active, waiting for a full burst in the FIFO
//   REQ   | request presented, address held until accepted
//   BURST | request accepted, waiting for the burst to finish writing
// ----------------------------------------------------------------------------
module wr3_addr_ctr #(
    parameter logic [31:0] START_ADDR     = 32'h0080_0000,
    parameter logic [31:0] BLOCK_SIZE     = 32'h0008_0000,
    parameter logic [31:0] IMAGE_BLOCK    = 32'h0007_0800,
    parameter logic [31:0] WR_NUM         = 32'd128,
    parameter int          FRAME_NUM      = 32,
    parameter int          ADDR_WIDTH     = 30,
    parameter int          FIFO_CNT_WIDTH = 12
) (
    input logic           clk,
    input logic           rst,
    wr3_addr_ctr_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, REQ, BURST} state_t;

    localparam logic [31:0]           FRAME_BURSTS = IMAGE_BLOCK / WR_NUM;
    localparam logic [31:0]           STEP_B       = WR_NUM * 32'd4;
    localparam logic [ADDR_WIDTH-1:0] BASE_B       = ADDR_WIDTH'(START_ADDR * 32'd4);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_B     = ADDR_WIDTH'(BLOCK_SIZE * 32'd4);
    localparam logic [4:0]            LAST_SLOT    = 5'(FRAME_NUM - 1);

    state_t                state, state_nxt;
    logic                  vs_d;
    logic                  vs_rise;
    logic [31:0]           offset, offset_nxt;
    logic [31:0]           burst_cnt, burst_cnt_nxt;
    logic                  pending, pending_nxt;
    logic [4:0]            img, img_nxt;
    logic                  frame_done, frame_done_nxt;
    logic                  valid, valid_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic                  fifo_full_burst;

    assign vs_rise         = bus.wr_vs & ~vs_d;
    assign burst_addr      = BASE_B + ADDR_WIDTH'(img) * STRIDE_B + ADDR_WIDTH'(offset);
    assign fifo_full_burst = 32'(bus.wr_fifo_cnt) >= WR_NUM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vs_d       <= 1'b0;
            offset     <= '0;
            burst_cnt  <= '0;
            pending    <= 1'b0;
            img        <= '0;
            frame_done <= 1'b0;
            valid      <= 1'b0;
            addr       <= '0;
        end else begin
            state      <= state_nxt;
            vs_d       <= bus.wr_vs;
            offset     <= offset_nxt;
            burst_cnt  <= burst_cnt_nxt;
            pending    <= pending_nxt;
            img        <= img_nxt;
            frame_done <= frame_done_nxt;
            valid      <= valid_nxt;
            addr       <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        offset_nxt     = offset;
        burst_cnt_nxt  = burst_cnt;
        pending_nxt    = pending;
        img_nxt        = img;
        frame_done_nxt = 1'b0;
        valid_nxt      = valid;
        addr_nxt       = addr;

        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt     = WAIT;
                    offset_nxt    = '0;
                    burst_cnt_nxt = '0;
                    pending_nxt   = 1'b0;
                end
            end
            WAIT: begin
                if (vs_rise) begin
                    // New sync before any request went out: restart the slot.
                    offset_nxt    = '0;
                    burst_cnt_nxt = '0;
                end else if (fifo_full_burst) begin
                    state_nxt = REQ;
                    valid_nxt = 1'b1;
                    addr_nxt  = burst_addr;
                end
            end
            REQ: begin
                // A request already on the bus is never withdrawn; remember the sync.
                if (vs_rise)
                    pending_nxt = 1'b1;
                if (bus.wr_ddr_ready) begin
                    state_nxt = BURST;
                    valid_nxt = 1'b0;
                end
            end
            BURST: begin
                if (vs_rise)
                    pending_nxt = 1'b1;
                if (bus.wr_burst_done) begin
                    pending_nxt = 1'b0;
                    if (pending) begin
                        state_nxt     = WAIT;
                        offset_nxt    = '0;
                        burst_cnt_nxt = '0;
                    end else if (burst_cnt + 32'd1 == FRAME_BURSTS) begin
                        // Frame finished; a sync arriving now starts the next slot directly.
                        frame_done_nxt = 1'b1;
                        img_nxt        = (img == LAST_SLOT) ? 5'd0 : img + 5'd1;
                        offset_nxt     = '0;
                        burst_cnt_nxt  = '0;
                        state_nxt      = vs_rise ? WAIT : IDLE;
                    end else if (vs_rise) begin
                        state_nxt     = WAIT;
                        offset_nxt    = '0;
                        burst_cnt_nxt = '0;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 32'd1;
                        offset_nxt    = offset + STEP_B;
                        state_nxt     = WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wr_ddr_valid  = valid;
    assign bus.wr_ddr_addr   = addr;
    assign bus.wr_image_cnt  = img;
    assign bus.wr_frame_done = frame_done;
    assign bus.wr_busy       = (state != IDLE);
endmodule

// File: tb/tb_wr3_addr_ctr.sv
// ----------------------------------------------------------------------------
// tb_wr3_addr_ctr
//   Bench for wr3_addr_ctr with a 512-word frame (4 bursts) and a 32-slot
//   ring. Timing of ready/done and FIFO levels are randomized; expected
//   addresses and frame counts come from a slot/burst index model.
// ----------------------------------------------------------------------------
module tb_wr3_addr_ctr;
    localparam int BURSTS = 4;
    localparam int SLOTS  = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wr3_addr_ctr_if #(.ADDR_WIDTH(30), .FIFO_CNT_WIDTH(12)) bus ();

    wr3_addr_ctr #(
        .START_ADDR    (32'h0080_0000),
        .BLOCK_SIZE    (32'h0008_0000),
        .IMAGE_BLOCK   (32'd512),
        .WR_NUM        (32'd128),
        .FRAME_NUM     (32),
        .ADDR_WIDTH    (30),
        .FIFO_CNT_WIDTH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int exp_img    = 0;
    int exp_burst  = 0;

    // Byte address of the next burst: ring base + slot stride + burst offset.
    function automatic logic [29:0] model_addr();
        return 30'(32'h0200_0000 + exp_img * 32'h0020_0000 + exp_burst * 512);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        bus.wr_fifo_cnt = 12'd0;
        bus.wr_vs = 1'b1;
        @(negedge clk);
        bus.wr_vs = 1'b0;
        @(negedge clk);
        chk("busy_after_vs", 32'(bus.wr_busy), 32'd1);
    endtask

    task automatic do_burst(input int ready_wait, input int done_wait,
                            input bit vs_in_wait, input bit vs_in_burst, input bit vs_with_done);
        int         low_cycles;
        bit         seen;
        logic [29:0] ea;
        bit         exp_fd;
        bit         exp_busy;
        low_cycles = $urandom_range(1, 3);
        // One short of a burst: no request, and stray done/ready are ignored.
        bus.wr_fifo_cnt  = 12'd127;
        bus.wr_ddr_ready = 1'b1;
        for (int i = 0; i < low_cycles; i++) begin
            bus.wr_burst_done = (i == 0);
            bus.wr_vs = vs_in_wait && (i == 0);
            @(negedge clk);
            bus.wr_burst_done = 1'b0;
            bus.wr_vs = 1'b0;
            chk("no_req_fifo127", 32'(bus.wr_ddr_valid), 32'd0);
        end
        if (vs_in_wait)
            exp_burst = 0;
        bus.wr_fifo_cnt  = ($urandom_range(0, 1) == 0) ? 12'd128 : 12'($urandom_range(128, 4095));
        bus.wr_ddr_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.wr_ddr_valid;
        end
        chk("req_seen", 32'(seen), 32'd1);
        ea = model_addr();
        chk("req_addr", 32'(bus.wr_ddr_addr), 32'(ea));
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.wr_ddr_valid), 32'd1);
            chk("hold_addr", 32'(bus.wr_ddr_addr), 32'(ea));
        end
        bus.wr_ddr_ready = 1'b1;
        @(negedge clk);
        bus.wr_ddr_ready = 1'b0;
        bus.wr_fifo_cnt  = 12'($urandom_range(0, 127));
        chk("valid_drop", 32'(bus.wr_ddr_valid), 32'd0);
        chk("busy_in_burst", 32'(bus.wr_busy), 32'd1);
        for (int i = 0; i < done_wait; i++) begin
            bus.wr_vs = vs_in_burst && (i == 0);
            @(negedge clk);
            bus.wr_vs = 1'b0;
        end
        bus.wr_burst_done = 1'b1;
        bus.wr_vs = vs_with_done;
        @(negedge clk);
        bus.wr_burst_done = 1'b0;
        bus.wr_vs = 1'b0;
        exp_fd   = 1'b0;
        exp_busy = 1'b1;
        if (vs_in_burst) begin
            exp_burst = 0;
        end else begin
            exp_burst++;
            if (exp_burst == BURSTS) begin
                exp_burst = 0;
                exp_img   = (exp_img + 1) % SLOTS;
                exp_fd    = 1'b1;
                exp_busy  = vs_with_done;
            end
        end
        chk("frame_done", 32'(bus.wr_frame_done), 32'(exp_fd));
        chk("image_cnt", 32'(bus.wr_image_cnt), 32'(exp_img));
        @(negedge clk);
        chk("frame_done_1cyc", 32'(bus.wr_frame_done), 32'd0);
        chk("busy_after_done", 32'(bus.wr_busy), 32'(exp_busy));
    endtask

    task automatic norm_burst();
        do_burst($urandom_range(0, 3), $urandom_range(1, 4), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst               = 1'b1;
        bus.wr_vs         = 1'b0;
        bus.wr_fifo_cnt   = 12'd0;
        bus.wr_ddr_ready  = 1'b0;
        bus.wr_burst_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.wr_ddr_valid), 32'd0);
        chk("rst_image_cnt", 32'(bus.wr_image_cnt), 32'd0);
        chk("rst_busy", 32'(bus.wr_busy), 32'd0);
        chk("rst_frame_done", 32'(bus.wr_frame_done), 32'd0);
        chk("rst_addr", 32'(bus.wr_ddr_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.wr_busy), 32'd0);

        // First frame: first request held off by ready for 10 cycles.
        start_frame();
        do_burst(10, 2, 1'b0, 1'b0, 1'b0);
        for (int b = 1; b < BURSTS; b++) norm_burst();

        // Remaining slots of the ring; the count wraps back to 0.
        for (int f = 1; f < SLOTS; f++) begin
            start_frame();
            for (int b = 0; b < BURSTS; b++) norm_burst();
        end
        chk("wrapped_image_cnt", 32'(bus.wr_image_cnt), 32'd0);

        // Sync during the second burst: frame restarts at the slot base.
        start_frame();
        norm_burst();
        do_burst($urandom_range(0, 3), $urandom_range(1, 4), 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < BURSTS; b++) norm_burst();

        // Sync while waiting for the FIFO before the third burst.
        start_frame();
        norm_burst();
        norm_burst();
        do_burst($urandom_range(0, 3), $urandom_range(1, 4), 1'b1, 1'b0, 1'b0);
        for (int b = 1; b < BURSTS; b++) norm_burst();

        // Sync coincident with the final burst_done: next slot without a new sync.
        start_frame();
        for (int b = 0; b < BURSTS - 1; b++) norm_burst();
        do_burst($urandom_range(0, 3), $urandom_range(1, 4), 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < BURSTS; b++) norm_burst();

        // Reset while a request is pending.
        start_frame();
        bus.wr_fifo_cnt = 12'd128;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.wr_ddr_valid;
        end
        chk("pre_rst_req_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.wr_fifo_cnt = 12'd0;
        exp_img   = 0;
        exp_burst = 0;
        chk("midrst_valid", 32'(bus.wr_ddr_valid), 32'd0);
        chk("midrst_image_cnt", 32'(bus.wr_image_cnt), 32'd0);
        chk("midrst_busy", 32'(bus.wr_busy), 32'd0);
        chk("midrst_frame_done", 32'(bus.wr_frame_done), 32'd0);
        start_frame();
        for (int b = 0; b < BURSTS; b++) norm_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
